// File: rtl/conv_out_collector.sv
// Collects N=(p-2)^2 convolution results per frame, saturates them to OW bits and drains them
// over a valid/ready port. Define CONV_OUT_RELU_EN to clamp negative sums to zero first.
module conv_out_collector #(
    parameter int unsigned p  = 5,
    parameter int unsigned m  = 8,
    parameter int unsigned DW = 20,
    parameter int unsigned OW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 avail,
    input  logic signed [DW-1:0] conv_in,
    input  logic                 done_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_ovf,
    output logic                 err_unf
);
    localparam int unsigned N  = (p - 2) * (p - 2);
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam int MaxI = (2 ** (OW - 1)) - 1;
    localparam int MinI = -(2 ** (OW - 1));
    localparam logic signed [DW-1:0] SatMax = DW'(MaxI);
    localparam logic signed [DW-1:0] SatMin = DW'(MinI);
    localparam logic [m-1:0] NCnt = m'(N);
    localparam logic [m-1:0] One  = m'(1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] WAITDONE = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [m-1:0]  wptr_q, wptr_d;
    logic [m-1:0]  rptr_q, rptr_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;
    logic [OW-1:0] mem_q [N];

    logic signed [DW-1:0] relu_in;
    logic [OW-1:0]        px;
    logic                 wr_en;
    logic [m-1:0]         cnt_next;

    always_comb begin
`ifdef CONV_OUT_RELU_EN
        relu_in = conv_in[DW-1] ? '0 : conv_in;
`else
        relu_in = conv_in;
`endif
        if (relu_in > SatMax) begin
            px = SatMax[OW-1:0];
        end else if (relu_in < SatMin) begin
            px = SatMin[OW-1:0];
        end else begin
            px = relu_in[OW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_ovf_d   = err_ovf_q;
        err_unf_d   = err_unf_q;
        wr_en       = 1'b0;
        cnt_next    = wptr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = COLLECT;
                    wptr_d    = '0;
                    rptr_d    = '0;
                    err_ovf_d = 1'b0;
                    err_unf_d = 1'b0;
                end
            end
            COLLECT: begin
                if (avail && (wptr_q < NCnt)) begin
                    wr_en    = 1'b1;
                    cnt_next = wptr_q + One;
                    wptr_d   = cnt_next;
                end
                // The transition sees the count including a same-edge write.
                if (done_in) begin
                    state_d = DRAIN;
                    if (cnt_next < NCnt) err_unf_d = 1'b1;
                end else if (cnt_next == NCnt) begin
                    state_d = WAITDONE;
                end
            end
            WAITDONE: begin
                if (avail) err_ovf_d = 1'b1;
                if (done_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (avail) err_ovf_d = 1'b1;
                if (wptr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                        if (out_last_q) state_d = IDLE;
                    end
                    // Refill the output register whenever it is empty or being consumed.
                    if ((!out_valid_q || out_ready) && (rptr_q < wptr_q)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = mem_q[rptr_q[AW-1:0]];
                        out_last_d  = ((rptr_q + One) == wptr_q);
                        rptr_d      = rptr_q + One;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= px;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Self-checking bench for conv_out_collector: directed and random frames scored against a
// queue-based model of saturation, frame length and error flags.
module tb_conv_out_collector;
    localparam int P  = 5;
    localparam int M  = 8;
    localparam int DW = 20;
    localparam int OW = 8;
    localparam int N  = (P - 2) * (P - 2);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 avail = 1'b0;
    logic                 done_in = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] conv_in = '0;
    logic                 out_valid, out_last, busy, err_ovf, err_unf;
    logic [OW-1:0]        out_data;

    int n_checks = 0;
    int n_fail = 0;
    logic [OW-1:0] exp_q[$];
    int vals[$];

    conv_out_collector #(.p(P), .m(M), .DW(DW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .avail(avail), .conv_in(conv_in),
        .done_in(done_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] model_px(input int v);
        int t;
        t = v;
`ifdef CONV_OUT_RELU_EN
        if (t < 0) t = 0;
`endif
        if (t > 127) return 8'h7F;
        if (t < -128) return 8'h80;
        return OW'(t);
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 400)) - 200;
            1: return int'($urandom_range(0, 2000)) - 1000;
            2: return int'($urandom_range(0, 1048574)) - 524287;
            default: return int'($urandom_range(0, 256)) - 128;
        endcase
    endfunction

    task automatic fill_random();
        vals.delete();
        for (int i = 0; i < 12; i++) vals.push_back(rnd_val());
    endtask

    // rmode: 0 always ready, 1 ready dropped for 4 cycles mid-drain, 2 random ready
    task automatic drain(input int rmode);
        int nexp, got, cyc;
        bit held, hold_last;
        logic [OW-1:0] hold_data;
        nexp = exp_q.size();
        got = 0;
        cyc = 0;
        held = 0;
        hold_last = 0;
        hold_data = '0;
        if (nexp == 0) begin
            out_ready = 1'b1;
            check("zero_entry_busy_in_drain", busy, 1);
            step();
        end else begin
            while (got < nexp && cyc < 200) begin
                case (rmode)
                    0: out_ready = 1'b1;
                    1: out_ready = !(cyc >= 3 && cyc <= 6);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hold_data);
                    check("hold_last", out_last, hold_last);
                end
                if (out_valid && out_ready) begin
                    check("drain_data", out_data, exp_q[got]);
                    check("drain_last", out_last, (got == nexp - 1));
                    got++;
                end
                held = out_valid && !out_ready;
                hold_data = out_data;
                hold_last = out_last;
                step();
                cyc++;
            end
            check("drain_transfers", got, nexp);
            if (rmode == 0) check("drain_cycles", cyc, nexp + 1);
        end
        check("idle_after_drain", busy, 0);
        check("no_valid_after_drain", out_valid, 0);
    endtask

    task automatic run_frame(input int n, input bit done_with_last, input bit start_mid,
                             input int rmode);
        exp_q.delete();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ovf_cleared", err_ovf, 0);
        check("unf_cleared", err_unf, 0);
        for (int i = 0; i < n; i++) begin
            avail = 1'b1;
            conv_in = DW'(vals[i]);
            if (start_mid && i == 2) start = 1'b1;
            if (done_with_last && i == n - 1) done_in = 1'b1;
            if (i < N) exp_q.push_back(model_px(vals[i]));
            step();
            start = 1'b0;
        end
        avail = 1'b0;
        if (!done_with_last || n == 0) begin
            done_in = 1'b1;
            step();
        end
        done_in = 1'b0;
        check("first_cycle_of_drain_no_valid", out_valid, 0);
        drain(rmode);
        check("err_ovf", err_ovf, (n > N));
        check("err_unf", err_unf, (n < N));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"}, err_ovf, 0);
        check({tag, "_unf"}, err_unf, 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        step();
        rst = 1'b1;

        // Values 1..9, all ready
        vals.delete();
        for (int i = 1; i <= 12; i++) vals.push_back(i);
        run_frame(9, 0, 0, 0);

        // Saturation corners, done_in on the same edge as the last write
        vals = '{300, -200, -5, 127, -128, 128, -129, 524287, -524288, 0, 0, 0};
        run_frame(9, 1, 0, 0);

        fill_random();
        run_frame(9, 0, 0, 1);

        fill_random();
        run_frame(6, 0, 0, 2);

        // Overrun with an ignored start in the middle of collection
        fill_random();
        run_frame(10, 0, 1, 0);

        fill_random();
        run_frame(0, 0, 0, 0);

        // Reset after 4 writes
        fill_random();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            avail = 1'b1;
            conv_in = DW'(vals[i]);
            step();
        end
        avail = 1'b0;
        rst = 1'b0;
        #1;
        check_all_zero("rst_collect");
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_quiet_valid", out_valid, 0);
            check("post_rst_quiet_busy", busy, 0);
        end
        fill_random();
        run_frame(9, 0, 0, 0);

        // Reset while an output is pending
        fill_random();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            avail = 1'b1;
            conv_in = DW'(vals[i]);
            step();
        end
        avail = 1'b0;
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        check_all_zero("rst_drain");
        step();
        rst = 1'b1;
        step();
        check("post_rst2_valid", out_valid, 0);
        fill_random();
        run_frame(9, 0, 0, 2);

        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_frame(int'($urandom_range(0, 11)), 0, 0, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
